parity_generator_checker: RTL and testbench

- Registered parity unit for a DATA_W-bit word. It works in two modes, chosen each cycle by `mode`.
- Generation mode (`mode`=0): produces even and odd parity bits for `data`.
- Check mode (`mode`=1): also verifies a received `parity_bit` against `data` under the even-parity convention.
- Sits at link/bus boundaries. Error statistics (count and sticky flag) are exposed for status registers.

---
 rtl/parity_pkg.sv | 12 +
 rtl/parity_generator_checker_sat_counter.sv | 20 ++
 rtl/parity_generator_checker.sv | 66 ++++++
 tb/tb_parity_generator_checker.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared constants for the parity generator/checker.
package parity_pkg;

  // Mode encodings for the per-cycle mode input
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  // Default widths
  localparam int DEF_DATA_W = 4;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/parity_generator_checker_sat_counter.sv
// Saturating up-counter with increment enable and async active-high reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;
  assign at_max = &count;

  // Count up on enable, hold once every bit is set so the value never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (inc && !at_max) count <= count + 1'b1;
  end

endmodule

// File: rtl/parity_generator_checker.sv
// Registered even/odd parity generator with an even-parity checker and
// saturating check/error statistics.
module parity_generator_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              parity_bit,
  input  logic              mode,
  output logic              even_parity,
  output logic              odd_parity,
  output logic              parity_valid,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  check_count,
  output logic [CNT_W-1:0]  err_count
);

  logic red;
  logic chk_en;
  logic mismatch;
  logic err_inc;

  assign red      = ^data;
  assign chk_en   = (mode == MODE_CHK);
  // Received bit is only meaningful in check mode; gating with chk_en keeps
  // an undriven parity_bit in generate mode out of every state update.
  assign mismatch = red ^ parity_bit;
  assign err_inc  = chk_en & mismatch;

  // Parity outputs track data every cycle; check result and sticky flag
  // update only in check mode (valid forced low in generate mode).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      even_parity  <= 1'b0;
      odd_parity   <= 1'b1;
      parity_valid <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      even_parity  <= red;
      odd_parity   <= ~red;
      parity_valid <= chk_en ? ~mismatch : 1'b0;
      if (err_inc) err_sticky <= 1'b1;
    end
  end

  // Every error is also a check, so err_count can never pass check_count
  // even though the two saturate independently.
  sat_counter #(.W(CNT_W)) u_check_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (chk_en),
    .count (check_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_parity_generator_checker.sv
// Self-checking bench: directed test-plan steps with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
// Two instances run side by side: default widths and a 2-bit counter build.
module tb_parity_generator_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic       parity_bit;
  logic       mode;

  logic       ev_a, od_a, pv_a, st_a;
  logic [7:0] cc_a, ec_a;
  logic       ev_b, od_b, pv_b, st_b;
  logic [1:0] cc_b, ec_b;

  int errors = 0;
  int checks = 0;
  bit en_cmp = 1'b0;

  // Behavioural model state
  int m_par, m_valid, m_sticky, m_cc8, m_ec8, m_cc2, m_ec2;

  always #5 clk = ~clk;

  parity_generator_checker #(.DATA_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .data(data), .parity_bit(parity_bit), .mode(mode),
    .even_parity(ev_a), .odd_parity(od_a), .parity_valid(pv_a),
    .err_sticky(st_a), .check_count(cc_a), .err_count(ec_a)
  );

  parity_generator_checker #(.DATA_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .data(data), .parity_bit(parity_bit), .mode(mode),
    .even_parity(ev_b), .odd_parity(od_b), .parity_valid(pv_b),
    .err_sticky(st_b), .check_count(cc_b), .err_count(ec_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: parity = odd number of ones; counters as bounded integers
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_par <= 0; m_valid <= 0; m_sticky <= 0;
      m_cc8 <= 0; m_ec8 <= 0; m_cc2 <= 0; m_ec2 <= 0;
    end else begin
      m_par <= $countones(data) % 2;
      if (mode) begin
        m_valid <= (($countones(data) + int'(parity_bit)) % 2 == 0) ? 1 : 0;
        m_cc8   <= (m_cc8 < 255) ? m_cc8 + 1 : 255;
        m_cc2   <= (m_cc2 < 3)   ? m_cc2 + 1 : 3;
        if (($countones(data) + int'(parity_bit)) % 2 == 1) begin
          m_sticky <= 1;
          m_ec8    <= (m_ec8 < 255) ? m_ec8 + 1 : 255;
          m_ec2    <= (m_ec2 < 3)   ? m_ec2 + 1 : 3;
        end
      end else begin
        m_valid <= 0;
      end
    end
  end

  // Compare DUT outputs with the model away from the active edge
  always @(negedge clk) begin
    if (en_cmp) begin
      check("a_even",   ev_a, m_par);
      check("a_odd",    od_a, 1 - m_par);
      check("a_valid",  pv_a, m_valid);
      check("a_sticky", st_a, m_sticky);
      check("a_cc",     cc_a, m_cc8);
      check("a_ec",     ec_a, m_ec8);
      check("b_even",   ev_b, m_par);
      check("b_valid",  pv_b, m_valid);
      check("b_sticky", st_b, m_sticky);
      check("b_cc",     cc_b, m_cc2);
      check("b_ec",     ec_b, m_ec2);
      check("a_ec_le_cc", (ec_a <= cc_a) ? 1 : 0, 1);
    end
  end

  task automatic cyc(input logic m, input logic [3:0] d, input logic p);
    @(negedge clk);
    mode = m; data = d; parity_bit = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_even"},   ev_a, 0);
    check({tag, "_odd"},    od_a, 1);
    check({tag, "_valid"},  pv_a, 0);
    check({tag, "_sticky"}, st_a, 0);
    check({tag, "_cc"},     cc_a, 0);
    check({tag, "_ec"},     ec_a, 0);
    check({tag, "_b_cc"},   cc_b, 0);
    check({tag, "_b_ec"},   ec_b, 0);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; data = 4'h0; parity_bit = 1'b0;
    #2;
    check_reset_vals("rst0");   // before any clock edge
    @(negedge clk);
    rst = 1'b0;
    en_cmp = 1'b1;

    // Generate mode
    cyc(1'b0, 4'b1011, 1'b0);
    check("gen1011_even", ev_a, 1);
    check("gen1011_odd",  od_a, 0);
    check("gen1011_valid", pv_a, 0);
    cyc(1'b0, 4'b1111, 1'b1);
    check("gen1111_even", ev_a, 0);
    check("gen1111_odd",  od_a, 1);
    cyc(1'b0, 4'b0110, 1'bx);
    cyc(1'b0, 4'b0001, 1'b1);
    check("gen_no_cc", cc_a, 0);
    check("gen_no_ec", ec_a, 0);
    check("gen_no_sticky", st_a, 0);

    // Check pass
    cyc(1'b1, 4'b1011, 1'b1);
    check("pass_valid", pv_a, 1);
    check("pass_cc", cc_a, 1);
    check("pass_ec", ec_a, 0);
    check("pass_sticky", st_a, 0);

    // Check fail, then sticky hold
    cyc(1'b1, 4'b1011, 1'b0);
    check("fail_valid", pv_a, 0);
    check("fail_ec", ec_a, 1);
    check("fail_sticky", st_a, 1);
    cyc(1'b1, 4'b0000, 1'b0);
    check("hold_sticky", st_a, 1);
    check("hold_valid", pv_a, 1);
    check("b_cc_sat_first", cc_b, 3);
    check("b_ec_before", ec_b, 1);

    // Saturation on the 2-bit build
    repeat (6) cyc(1'b1, 4'b1011, 1'b0);
    check("sat_b_cc", cc_b, 3);
    check("sat_b_ec", ec_b, 3);
    check("sat_a_cc", cc_a, 9);
    check("sat_a_ec", ec_a, 7);

    // Async reset between edges
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("arst");
    #1 rst = 1'b0;

    // Randomized traffic with occasional mid-cycle reset
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      mode       = 1'($urandom_range(0, 2) != 0);
      data       = 4'($urandom);
      parity_bit = 1'($urandom);
      if (!mode && ($urandom_range(0, 3) == 0)) parity_bit = 1'bx;
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
